// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register front end: FSM states and
// command-byte field positions, with small decode helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  localparam int unsigned CMD_RW_BIT   = 32'd7;
  localparam int unsigned CMD_EN_BIT   = 32'd6;
  localparam int unsigned CMD_ADDR_MSB = 32'd5;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_RW_BIT];
  endfunction

  function automatic logic cmd_enabled(input logic [7:0] cmd);
    return cmd[CMD_EN_BIT];
  endfunction

endpackage

// File: rtl/spi_reg_frontend_chk.sv
// Protocol checks for the SPI register front end: strobe shape and
// consistency of the synchronized edge pulses with their levels.
module spi_reg_frontend_chk (
  input logic clk,
  input logic rst,
  input logic reg_we,
  input logic reg_re,
  input logic sclk_lvl,
  input logic sclk_rise,
  input logic sclk_fall,
  input logic cs_lvl,
  input logic cs_rise,
  input logic cs_fall,
  input logic mosi_rise,
  input logic mosi_fall
);

  a_we_re_excl: assert property (@(posedge clk) disable iff (rst) !(reg_we && reg_re));
  a_we_single:  assert property (@(posedge clk) disable iff (rst) reg_we |=> !reg_we);
  a_re_single:  assert property (@(posedge clk) disable iff (rst) reg_re |=> !reg_re);

  // A detected edge must still agree with the synchronized level: a violation
  // means sclk/cs_n phases are shorter than the synchronizer can resolve.
  a_sclk_rise:  assert property (@(posedge clk) disable iff (rst) sclk_rise |-> sclk_lvl);
  a_sclk_fall:  assert property (@(posedge clk) disable iff (rst) sclk_fall |-> !sclk_lvl);
  a_cs_rise:    assert property (@(posedge clk) disable iff (rst) cs_rise |-> cs_lvl);
  a_cs_fall:    assert property (@(posedge clk) disable iff (rst) cs_fall |-> !cs_lvl);
  a_mosi_edge:  assert property (@(posedge clk) disable iff (rst) !(mosi_rise && mosi_fall));

endmodule

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered one-cycle
// rise/fall pulses. STAGES must be at least 2.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronizer chain plus edge-detect flop; edges appear STAGES+1 cycles after the pin moves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_frontend.sv
// SPI mode-0 slave that decodes command/data byte pairs into one-cycle
// register-file write/read strobes and returns read data on miso.
module spi_reg_frontend
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata
);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk),
    .rst_i (rst),
    .din_i (sclk),
    .sync_o(sclk_lvl_s),
    .rise_o(sclk_rise_s),
    .fall_o(sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i (clk),
    .rst_i (rst),
    .din_i (cs_n),
    .sync_o(cs_lvl_s),
    .rise_o(cs_rise_s),
    .fall_o(cs_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk),
    .rst_i (rst),
    .din_i (mosi),
    .sync_o(mosi_s),
    .rise_o(mosi_rise_s),
    .fall_o(mosi_fall_s)
  );

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              ld_q, ld_d;
  logic [7:0]        rx_bit_s;

  // Next-state decode: cs_n edges override everything, otherwise the FSM consumes sclk edges.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    cmd_wr_d  = cmd_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    ld_d      = re_q;
    rx_bit_s  = {rx_q[6:0], mosi_s};

    if (cs_rise_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else if (cs_fall_s) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else begin
      // Read data arrives the cycle after reg_re and is parked for the data byte.
      if (ld_q) begin
        tx_d = reg_rdata;
      end else begin
        tx_d = tx_q;
      end

      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          rx_d      = 8'h00;
          tx_d      = 8'h00;
          miso_d    = 1'b0;
        end

        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise_s) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = ST_DATA;
              bit_cnt_d = 3'd0;
              rx_d      = 8'h00;
              cmd_wr_d  = cmd_is_write(rx_bit_s) & cmd_enabled(rx_bit_s);
              if (cmd_enabled(rx_bit_s)) begin
                addr_d = ADDR_W'(rx_bit_s[CMD_ADDR_MSB:0]);
                re_d   = ~cmd_is_write(rx_bit_s);
              end else begin
                addr_d = addr_q;
                re_d   = 1'b0;
              end
            end else begin
              rx_d      = rx_bit_s;
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            rx_d = rx_q;
          end
        end

        ST_DATA: begin
          if (sclk_fall_s) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            miso_d = miso_q;
          end
          if (sclk_rise_s) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = ST_DONE;
              bit_cnt_d = 3'd0;
              rx_d      = 8'h00;
              tx_d      = 8'h00;
              miso_d    = 1'b0;
              if (cmd_wr_q) begin
                wdata_d = rx_bit_s;
                we_d    = 1'b1;
              end else begin
                wdata_d = wdata_q;
                we_d    = 1'b0;
              end
            end else begin
              rx_d      = rx_bit_s;
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            rx_d = rx_q;
          end
        end

        ST_DONE: begin
          bit_cnt_d = 3'd0;
          tx_d      = 8'h00;
          miso_d    = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      cmd_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      cmd_wr_q  <= cmd_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      ld_q      <= ld_d;
    end
  end

  assign miso      = miso_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;

  spi_reg_frontend_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .reg_we   (we_q),
    .reg_re   (re_q),
    .sclk_lvl (sclk_lvl_s),
    .sclk_rise(sclk_rise_s),
    .sclk_fall(sclk_fall_s),
    .cs_lvl   (cs_lvl_s),
    .cs_rise  (cs_rise_s),
    .cs_fall  (cs_fall_s),
    .mosi_rise(mosi_rise_s),
    .mosi_fall(mosi_fall_s)
  );

endmodule
